cell_addr_sequencer: RTL
========================

// Module: cell_addr_sequencer
// PURPOSE
//  Sequential, parametrised successor to the combinational 10x10 cell address decoder.
//  Latches a cell origin and row stride on a start pulse, then streams the cell's pixel
//  addresses row-major, LANES addresses per beat, under valid/ready backpressure.
//  Sits between the HOG window controller and the frame-buffer read port; no multipliers.
// PARAMETERS
//  ADDR_W   14  frame-buffer address width
//  COL_W    7   width of column origin and row stride inputs
//  CELL_H   10  cell height in pixel rows (>=1)
//  CELL_W   10  cell width in pixels (>=1, multiple of LANES)
//  LANES    1   consecutive addresses emitted per beat (1,2,5,10 legal for CELL_W=10)
// PORTS
//  iCLK         in   1              clock, rising edge
//  iRST_n       in   1              asynchronous active-low reset
//  iSTART       in   1              start request; sampled only in IDLE
//  iBEGIN_ROW   in   ADDR_W         address offset of the cell's first row
//  iBEGIN_COL   in   COL_W          column of the cell's first pixel
//  iROW_STRIDE  in   COL_W          pixels per image row (66 for current frame buffer)
//  oADDR        out  LANES*ADDR_W   lane k at [k*ADDR_W +: ADDR_W] = base+col+k
//  oVALID       out  1              oADDR holds a valid beat
//  iREADY       in   1              consumer accepts beat when oVALID&&iREADY
//  oLAST        out  1              current beat is the cell's final beat
//  oROW_IDX     out  $clog2(CELL_H) row index (0..CELL_H-1) of current beat
//  oCOL_IDX     out  $clog2(CELL_W) column index of lane 0 of current beat
//  oBUSY        out  1              state is RUN
//  oDONE        out  1              one-cycle pulse after final handshake
// BEHAVIOUR
//  Reset (async, iRST_n=0): state IDLE; oADDR=0, oVALID=0, oLAST=0, oROW_IDX=0,
//   oCOL_IDX=0, oBUSY=0, oDONE=0; internal base/col/counters cleared. Reset mid-cell aborts, no oDONE.
//  States: IDLE -> RUN on iSTART; RUN -> IDLE on handshake with oLAST=1.
//  IDLE: iSTART=1 at edge t latches origin/stride; at t+1: oVALID=1, oBUSY=1, first beat
//   addresses iBEGIN_ROW+iBEGIN_COL+k (latency 1).
//  RUN: beat advances only on oVALID&&iREADY. Without handshake all outputs hold stable.
//   oVALID stays 1 continuously in RUN (no bubbles); one beat per cycle at iREADY=1.
//  Order: col_idx steps by LANES to CELL_W-LANES, then wraps to 0 and row_idx++;
//   row base register += stride on row wrap (accumulate, no multiply).
//  oLAST=1 iff row_idx=CELL_H-1 and col_idx=CELL_W-LANES.
//  Final handshake at edge t: at t+1 state IDLE, oVALID=0, oLAST=0, oBUSY=0, oDONE=1
//   (one cycle). iSTART sampled at t+1 is accepted (back-to-back cells, 1 idle cycle).
//  iSTART in RUN ignored; origin/stride inputs ignored except on accepted start.
//  Arithmetic: base+col+k computed at ADDR_W+1 bits, truncated to ADDR_W (wraps mod 2^ADDR_W).
//   Column and stride zero-extended to ADDR_W before add. Stride 0 legal (rows repeat).
//  Beats per cell = CELL_H*CELL_W/LANES; 100 at defaults.
// STRUCTURE
//  hog_pkg: ADDR_W, COL_W, CELL_H, CELL_W defaults, FB_ROW_STRIDE=66, state enum {IDLE,RUN}.
//  One generate loop for lane adders; no sub-module needed (lane add is a single expression).
//  Registered outputs; next-state and counter logic in one always block.
// TESTING
//  1 Defaults, start row=0 col=24 stride=66, iREADY=1 -> 100 beats, first 24, 11th 90,
//    last 627 with oLAST=1, oDONE one cycle after, oBUSY low.
//  2 LANES=2, same start -> 50 beats; first beat {25,24}; last beat {627,626}, oLAST=1.
//  3 Backpressure: iREADY low on beats 3..7 -> oADDR/oROW_IDX/oCOL_IDX frozen, no skipped
//    or duplicated address; total beats still 100.
//  4 Wrap: row=16300 col=100 stride=66 -> first 16, second 17; addresses mod 16384.
//  5 iSTART pulsed mid-RUN with new origin -> ignored; start on oDONE cycle -> new cell
//    first beat next cycle.
//  6 iRST_n low at beat 40 (async, mid-cycle) -> all outputs 0 immediately, no oDONE;
//    fresh start after release begins at beat 0.

Source files
------------

// File: rtl/cell_addr_sequencer_pkg.sv
// Shared defaults and state encoding for the cell address sequencer.
package cell_addr_sequencer_pkg;

    localparam int unsigned ADDR_W_DEF    = 14;
    localparam int unsigned COL_W_DEF     = 7;
    localparam int unsigned CELL_H_DEF    = 10;
    localparam int unsigned CELL_W_DEF    = 10;
    localparam int unsigned FB_ROW_STRIDE = 66;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

endpackage

// File: rtl/cell_addr_sequencer.sv
// Streams the pixel addresses of one cell row-major, LANES per beat, with valid/ready flow
// control. Row bases are accumulated by adding the stride, so no multiplier is needed.
module cell_addr_sequencer
    import cell_addr_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned COL_W  = COL_W_DEF,
    parameter int unsigned CELL_H = CELL_H_DEF,
    parameter int unsigned CELL_W = CELL_W_DEF,
    parameter int unsigned LANES  = 1,
    localparam int unsigned RowIdxW = (CELL_H > 1) ? $clog2(CELL_H) : 1,
    localparam int unsigned ColIdxW = (CELL_W > 1) ? $clog2(CELL_W) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [ADDR_W-1:0]         begin_row_i,
    input  logic [COL_W-1:0]          begin_col_i,
    input  logic [COL_W-1:0]          row_stride_i,
    output logic [LANES*ADDR_W-1:0]   addr_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      last_o,
    output logic [RowIdxW-1:0]        row_idx_o,
    output logic [ColIdxW-1:0]        col_idx_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam logic [RowIdxW-1:0] RowLast = RowIdxW'(CELL_H - 1);
    localparam logic [ColIdxW-1:0] ColLast = ColIdxW'(CELL_W - LANES);
    localparam logic [ColIdxW-1:0] ColStep = ColIdxW'(LANES);

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         row_start_q, row_start_d;
    logic [ADDR_W-1:0]         addr0_q, addr0_d;
    logic [ADDR_W-1:0]         stride_q, stride_d;
    logic [RowIdxW-1:0]        row_q, row_d;
    logic [ColIdxW-1:0]        col_q, col_d;
    logic                      last_q, last_d;
    logic                      done_q, done_d;
    logic [LANES*ADDR_W-1:0]   addr_q, addr_d;

    // row_start tracks origin + column + row*stride; addr0 is lane 0 of the current beat.
    always_comb begin
        state_d     = state_q;
        row_start_d = row_start_q;
        addr0_d     = addr0_q;
        stride_d    = stride_q;
        row_d       = row_q;
        col_d       = col_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d     = StRun;
                    row_start_d = begin_row_i + ADDR_W'(begin_col_i);
                    addr0_d     = row_start_d;
                    stride_d    = ADDR_W'(row_stride_i);
                    row_d       = '0;
                    col_d       = '0;
                end
            end
            StRun: begin
                if (ready_i) begin
                    if (col_q == ColLast) begin
                        col_d = '0;
                        if (row_q == RowLast) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                            row_d   = '0;
                        end else begin
                            row_d       = row_q + RowIdxW'(1);
                            row_start_d = row_start_q + stride_q;
                            addr0_d     = row_start_d;
                        end
                    end else begin
                        col_d   = col_q + ColStep;
                        addr0_d = addr0_q + ADDR_W'(LANES);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        last_d = (state_d == StRun) && (row_d == RowLast) && (col_d == ColLast);
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign addr_d[k*ADDR_W +: ADDR_W] = addr0_d + ADDR_W'(k);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            row_start_q <= '0;
            addr0_q     <= '0;
            stride_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            row_start_q <= row_start_d;
            addr0_q     <= addr0_d;
            stride_q    <= stride_d;
            row_q       <= row_d;
            col_q       <= col_d;
            last_q      <= last_d;
            done_q      <= done_d;
            addr_q      <= addr_d;
        end
    end

    assign addr_o    = addr_q;
    assign valid_o   = (state_q == StRun);
    assign busy_o    = (state_q == StRun);
    assign last_o    = last_q;
    assign row_idx_o = row_q;
    assign col_idx_o = col_q;
    assign done_o    = done_q;

endmodule
